// File: rtl/rgb_pkg.sv
// Shared types and helpers for the RGB fade sequencer.
//   channel_t : active colour channel (R, G, B)
//   state_t   : fade phase (IDLE, RAMP_UP, HOLD, RAMP_DOWN)
//   ch_slot   : bit offset of a channel inside the packed {B,G,R} duty bus
//   ch_next   : R -> G -> B -> R rotation
package rgb_pkg;

  localparam int unsigned DUTY_W_DEF = 8;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } channel_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  // R sits in the low slot, B in the high slot.
  function automatic int unsigned ch_slot(input channel_t ch, input int unsigned w);
    int unsigned v_idx;
    v_idx = 32'(ch);
    return v_idx * w;
  endfunction

  function automatic channel_t ch_next(input channel_t ch);
    channel_t v_nxt;
    case (ch)
      CH_R:    v_nxt = CH_G;
      CH_G:    v_nxt = CH_B;
      default: v_nxt = CH_R;
    endcase
    return v_nxt;
  endfunction

endpackage

// File: rtl/rgb_step_timer.sv
// Fade step timing: prescaler, pending-tick latch and sticky overrun flag.
//   clk, rst      : clock, synchronous active-high reset
//   en            : run enable; low freezes the prescaler
//   step_taken    : the sequencer consumed the pending tick this cycle
//   tick_pending  : a step is owed to the sequencer (registered)
//   overrun       : a tick was lost while one was already owed (sticky)
module rgb_step_timer #(
  parameter int unsigned TICK_DIV = 390625
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic step_taken,
  output logic tick_pending,
  output logic overrun
);

  localparam int unsigned      PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] r_presc;
  logic             r_pending;
  logic             r_overrun;
  logic             w_tick;

  assign w_tick = en && (r_presc == PRE_LAST);

  // Prescaler: free-runs while enabled, holds while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (en) begin
      r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
    end
  end

  // A tick landing on the same cycle as a step re-arms the latch instead of being lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_tick) begin
        r_pending <= 1'b1;
      end else if (step_taken) begin
        r_pending <= 1'b0;
      end
      if (w_tick && r_pending && !step_taken) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign tick_pending = r_pending;
  assign overrun      = r_overrun;

endmodule

// File: rtl/rgb_fade_sequencer.sv
// RGB fade pattern generator feeding the PWM stage over valid/ready.
// Each channel ramps 1..DUTY_CAP, holds DUTY_CAP for HOLD_STEPS beats, ramps
// back down to 0, then the next channel (R -> G -> B -> R) takes over.
//   clk, rst   : clock, synchronous active-high reset
//   en         : run enable (halts tick generation only)
//   duty       : {B,G,R} duty words, one slot active per beat (registered)
//   out_valid  : beat valid (registered)
//   out_ready  : downstream accepts the beat
//   cycle_done : pulses in the cycle the final B level-0 beat is accepted
//   overrun    : sticky lost-tick flag (registered)
module rgb_fade_sequencer
  import rgb_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 390625,
  parameter int unsigned DUTY_W     = DUTY_W_DEF,
  parameter int unsigned DUTY_CAP   = 128,
  parameter int unsigned HOLD_STEPS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [3*DUTY_W-1:0] duty,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                cycle_done,
  output logic                overrun
);

  localparam int unsigned       DUTY_BUS_W  = 3 * DUTY_W;
  localparam int unsigned       HCNT_W      = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;
  localparam int unsigned       HOLD_LAST   = (HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0;
  localparam logic [DUTY_W-1:0] CAP_L       = DUTY_W'(DUTY_CAP);
  localparam logic [HCNT_W-1:0] HOLD_LAST_C = HCNT_W'(HOLD_LAST);

  state_t                  r_state;
  state_t                  w_state_nxt;
  channel_t                r_ch;
  channel_t                w_ch_nxt;
  logic [DUTY_W-1:0]       r_level;
  logic [DUTY_W-1:0]       w_level_nxt;
  logic [HCNT_W-1:0]       r_hold_cnt;
  logic [HCNT_W-1:0]       w_hold_nxt;
  logic [DUTY_BUS_W-1:0]   r_duty;
  logic [DUTY_BUS_W-1:0]   w_duty_nxt;
  logic                    r_valid;
  logic                    r_last;
  logic                    w_last_nxt;
  logic                    w_pending;
  logic                    w_step;
  logic                    w_accept;

  rgb_step_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .step_taken   (w_step),
    .tick_pending (w_pending),
    .overrun      (overrun)
  );

  // A step may load a new beat whenever the output slot is free or being drained.
  assign w_step   = w_pending && (!r_valid || out_ready);
  assign w_accept = r_valid && out_ready;

  // Next sequence position and the beat it produces.
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_level_nxt = r_level;
    w_hold_nxt  = r_hold_cnt;

    case (r_state)
      IDLE, RAMP_UP: begin
        w_level_nxt = r_level + DUTY_W'(1);
        w_state_nxt = RAMP_UP;
        if (w_level_nxt == CAP_L) begin
          w_hold_nxt  = '0;
          w_state_nxt = (HOLD_STEPS > 0) ? HOLD : RAMP_DOWN;
        end
      end
      HOLD: begin
        w_hold_nxt = r_hold_cnt + HCNT_W'(1);
        if (r_hold_cnt == HOLD_LAST_C) begin
          w_state_nxt = RAMP_DOWN;
        end
      end
      RAMP_DOWN: begin
        w_level_nxt = r_level - DUTY_W'(1);
        // The level-0 beat still belongs to this channel; rotate for the next one.
        if (r_level == DUTY_W'(1)) begin
          w_state_nxt = RAMP_UP;
          w_ch_nxt    = ch_next(r_ch);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_duty_nxt = DUTY_BUS_W'(w_level_nxt) << ch_slot(r_ch, DUTY_W);
    w_last_nxt = (r_ch == CH_B) && (w_level_nxt == '0);
  end

  // Sequence state and output beat advance together on a step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ch       <= CH_R;
      r_level    <= '0;
      r_hold_cnt <= '0;
      r_duty     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
    end else if (w_step) begin
      r_state    <= w_state_nxt;
      r_ch       <= w_ch_nxt;
      r_level    <= w_level_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_duty     <= w_duty_nxt;
      r_valid    <= 1'b1;
      r_last     <= w_last_nxt;
    end else if (w_accept) begin
      r_valid    <= 1'b0;
    end
  end

  assign duty       = r_duty;
  assign out_valid  = r_valid;
  assign cycle_done = r_valid && out_ready && r_last;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Self-checking bench for rgb_fade_sequencer (TICK_DIV=4, DUTY_CAP=3,
// HOLD_STEPS=2) plus a TICK_DIV=1 instance for the back-to-back case.
module tb_rgb_fade_sequencer;

  localparam int TD  = 4;
  localparam int CAP = 3;
  localparam int HS  = 2;
  localparam int BPC = 2 * CAP + HS;
  localparam int NB  = 3 * BPC;

  logic        clk = 1'b0;
  logic        rst, en, out_ready;
  logic [23:0] duty;
  logic        out_valid, cycle_done, overrun;

  logic        rst1, en1, rdy1;
  logic [23:0] duty1;
  logic        v1, cd1, ov1;

  always #5 clk = ~clk;

  rgb_fade_sequencer #(.TICK_DIV(TD), .DUTY_W(8), .DUTY_CAP(CAP), .HOLD_STEPS(HS)) u_dut (
    .clk(clk), .rst(rst), .en(en), .duty(duty), .out_valid(out_valid),
    .out_ready(out_ready), .cycle_done(cycle_done), .overrun(overrun)
  );

  rgb_fade_sequencer #(.TICK_DIV(1), .DUTY_W(8), .DUTY_CAP(CAP), .HOLD_STEPS(HS)) u_dut1 (
    .clk(clk), .rst(rst1), .en(en1), .duty(duty1), .out_valid(v1),
    .out_ready(rdy1), .cycle_done(cd1), .overrun(ov1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: beat-index view of the fade pattern.
  int          m_presc, m_idx, m_cur;
  bit          m_pend, m_valid, m_ovr, m_known;
  logic [23:0] m_duty;

  typedef struct {
    logic        r, e, rd;
    bit          chk;
    logic        v;
    logic [23:0] d;
  } vec_t;

  vec_t tbl[16];
  int   exp_r[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Beat k of a full colour cycle, straight from the ramp/hold/ramp rule.
  function automatic logic [23:0] beat_duty(input int k);
    int ch, j, lvl;
    ch = k / BPC;
    j  = k % BPC;
    if (j < CAP)           lvl = j + 1;
    else if (j < CAP + HS) lvl = CAP;
    else                   lvl = 2 * CAP + HS - 1 - j;
    return 24'(lvl) << (8 * ch);
  endfunction

  task automatic model_step(input logic r, input logic e, input logic rd);
    bit tick, step, acc;
    if (r) begin
      m_presc = 0; m_pend = 0; m_valid = 0; m_ovr = 0;
      m_idx = 0; m_cur = 0; m_duty = '0; m_known = 1;
    end else begin
      tick = e && (m_presc == TD - 1);
      step = m_pend && (!m_valid || rd);
      acc  = m_valid && rd;
      if (e) m_presc = tick ? 0 : m_presc + 1;
      if (tick && m_pend && !step) m_ovr = 1;
      if (tick) m_pend = 1;
      else if (step) m_pend = 0;
      if (step) begin
        m_duty  = beat_duty(m_idx);
        m_cur   = m_idx;
        m_idx   = (m_idx + 1) % NB;
        m_valid = 1;
      end else if (acc) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic rd);
    @(negedge clk);
    rst = r; en = e; out_ready = rd;
    #1;
  endtask

  task automatic mcheck();
    if (m_known) begin
      check("valid", 32'(out_valid), 32'(m_valid));
      check("duty", 32'(duty), 32'(m_duty));
      check("cycle_done", 32'(cycle_done), 32'(m_valid && out_ready && (m_cur == NB - 1)));
      check("overrun", 32'(overrun), 32'(m_ovr));
    end
    model_step(rst, en, out_ready);
  endtask

  task automatic cyc(input logic r, input logic e, input logic rd);
    drive(r, e, rd);
    mcheck();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nb, ncd, cd_at, k_first, cnt, cd_k;
    bit  seen, v_ok;

    rst = 1'b1; en = 1'b0; out_ready = 1'b1;
    rst1 = 1'b1; en1 = 1'b0; rdy1 = 1'b1;
    m_known = 0;
    exp_r = '{1, 2, 3, 3, 3, 2, 1, 0};

    // Reset, first two beats, and a short stall -- expected values worked by hand.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 24'h1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h1};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h2};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h2};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 24'h2};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h2};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 24'h3};

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].r, tbl[i].e, tbl[i].rd);
      if (tbl[i].chk) begin
        check($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].v));
        check($sformatf("tbl%0d_duty", i), 32'(duty), 32'(tbl[i].d));
        check($sformatf("tbl%0d_ovr", i), 32'(overrun), 32'h0);
      end
      mcheck();
    end

    // Full colour cycle with free-flowing output.
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    nb = 0; ncd = 0; cd_at = -1;
    for (int i = 0; i < 120; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      if (out_valid === 1'b1) begin
        nb++;
        if (nb <= 8) begin
          check("r_slot_seq", 32'(duty[7:0]), 32'(exp_r[nb-1]));
          check("gb_slots_zero", 32'(duty[23:8]), 32'h0);
        end
      end
      if (cycle_done === 1'b1) begin
        ncd++;
        cd_at = nb;
      end
    end
    check("cycle_done_count", 32'(ncd), 32'd1);
    check("cycle_done_beat", 32'(cd_at), 32'd24);

    // Backpressure for 6 cycles: no overrun, next beat right after acceptance.
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      if (out_valid === 1'b1) seen = 1;
    end
    check("bp_valid_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    check("bp_next_beat", 32'(out_valid), 32'd1);
    check("bp_no_overrun", 32'(overrun), 32'd0);

    // Backpressure for 10 cycles: overrun sets and sticks, sequence continues.
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      if (out_valid === 1'b1) seen = 1;
    end
    check("ovr_valid_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b0);
    check("ovr_set", 32'(overrun), 32'd1);
    for (int i = 0; i < 60; i++) cyc(1'b0, 1'b1, 1'b1);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Enable freeze in HOLD.
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    nb = 0;
    for (int i = 0; i < 40 && nb < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      if (out_valid === 1'b1) nb++;
    end
    check("frz_reach_hold", 32'(nb), 32'd4);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if (out_valid === 1'b1) cnt++;
    end
    check("frz_no_beats", 32'(cnt), 32'd0);
    k_first = -1;
    for (int k = 0; k < 10 && k_first < 0; k++) begin
      cyc(1'b0, 1'b1, 1'b1);
      if (out_valid === 1'b1) begin
        k_first = k;
        check("frz_resume_duty", 32'(duty), 32'h3);
      end
    end
    check("frz_resume_latency", 32'(k_first), 32'd3);

    // Reset during G ramp-down.
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    nb = 0;
    for (int i = 0; i < 80 && nb < 14; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      if (out_valid === 1'b1) nb++;
    end
    check("rst_mid_beat14", 32'(duty), 32'h0200);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_duty", 32'(duty), 32'h0);
    check("rst_mid_ovr", 32'(overrun), 32'd0);
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      if (out_valid === 1'b1) begin
        seen = 1;
        check("rst_first_beat", 32'(duty), 32'h1);
      end
    end
    check("rst_first_seen", 32'(seen), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
    end

    // TICK_DIV=1: a beat every cycle, full cycle 25 cycles after en rises.
    @(negedge clk); rst1 = 1'b1;
    @(negedge clk); rst1 = 1'b1;
    v_ok = 1; cd_k = -1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      rst1 = 1'b0; en1 = 1'b1; rdy1 = 1'b1;
      #1;
      if (k < 2) check("td1_idle", 32'(v1), 32'd0);
      else if (k <= 25) v_ok = v_ok && (v1 === 1'b1);
      if (k == 2) check("td1_first_beat", 32'(duty1), 32'h1);
      if (k == 25) check("td1_last_beat", 32'(duty1), 32'h0);
      if (cd1 === 1'b1 && cd_k < 0) cd_k = k;
    end
    check("td1_back_to_back", 32'(v_ok), 32'd1);
    check("td1_cycle_done_at", 32'(cd_k), 32'd25);
    check("td1_no_overrun", 32'(ov1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
